// File: rtl/flasher_pkg.sv
// Shared constants and state type for the bound flasher blocks
// (bound_flasher_ctrl, next_counter_generator, lamp_decoder).
package flasher_pkg;

    localparam logic [1:0] COUNT_DIS     = 2'b00;
    localparam logic [1:0] COUNT_UP_EN   = 2'b01;
    localparam logic [1:0] COUNT_DOWN_EN = 2'b10;
    localparam logic [1:0] COUNT_HOLD    = 2'b11;

    localparam logic [4:0] COUNTER_INIT = 5'd0;
    localparam logic [4:0] LAMP_MAX     = 5'd16;
    localparam logic [4:0] LAMP_LOW     = 5'd5;
    localparam logic [4:0] LAMP_MID     = 5'd10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UP16,
        ST_DN5,
        ST_UP10,
        ST_DN0A,
        ST_UP5,
        ST_DN0B
    } flash_state_t;

    // Counter command that a state issues while it is being entered or held
    function automatic logic [1:0] state_cmd(input flash_state_t st);
        logic [1:0] cmd;
        cmd = COUNT_DIS;
        case (st)
            ST_UP16, ST_UP10, ST_UP5: cmd = COUNT_UP_EN;
            ST_DN5, ST_DN0A, ST_DN0B: cmd = COUNT_DOWN_EN;
            default:                  cmd = COUNT_DIS;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/lamp_decoder.sv
// Counter to thermometer lamp vector: lamp[i] is lit when counter > i,
// so any value at or above LAMP_N lights every lamp.
module lamp_decoder
    import flasher_pkg::*;
#(
    parameter int LAMP_N = 16
) (
    input  logic [4:0]        counter,
    output logic [LAMP_N-1:0] lamp
);

    always_comb begin
        lamp = '0;
        for (int i = 0; i < LAMP_N; i++) begin
            lamp[i] = (int'(counter) > i);
        end
    end

endmodule

// File: rtl/bound_flasher_ctrl.sv
// Sequencing FSM for the bound flasher: walks 0->16->5->10->0->5->0.
// Kickback at DN5/DN0A is enabled by defining FLASHER_KICKBACK_EN.
module bound_flasher_ctrl
    import flasher_pkg::*;
#(
    parameter int LAMP_N = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flick,
    input  logic [4:0]        counter,
    output logic [1:0]        count_state,
    output logic [4:0]        counter_load,
    output logic              counter_load_en,
    output logic [LAMP_N-1:0] lamp,
    output logic              busy
);

`ifdef FLASHER_KICKBACK_EN
    localparam logic KICKBACK = 1'b1;
`else
    localparam logic KICKBACK = 1'b0;
`endif

    flash_state_t state;
    flash_state_t state_next;
    logic         illegal;
    logic         kick_req;

    assign illegal  = (counter > LAMP_MAX);
    assign kick_req = KICKBACK & flick;

    // An out-of-range counter outranks any target hit or kickback
    always_comb begin
        state_next = state;
        if (illegal) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (flick)                  state_next = ST_UP16;
                ST_UP16: if (counter == LAMP_MAX)    state_next = ST_DN5;
                ST_DN5:  if (counter == LAMP_LOW)    state_next = kick_req ? ST_UP16 : ST_UP10;
                ST_UP10: if (counter == LAMP_MID)    state_next = ST_DN0A;
                ST_DN0A: if (counter == COUNTER_INIT) state_next = kick_req ? ST_UP10 : ST_UP5;
                ST_UP5:  if (counter == LAMP_LOW)    state_next = ST_DN0B;
                ST_DN0B: if (counter == COUNTER_INIT) state_next = ST_IDLE;
                default:                             state_next = ST_IDLE;
            endcase
        end
    end

    // Commands follow the next state so the counter turns around without dwelling
    always_comb begin
        count_state     = rst_n ? state_cmd(state_next) : COUNT_DIS;
        counter_load_en = rst_n & illegal;
        counter_load    = COUNTER_INIT;
        busy            = rst_n && (state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    lamp_decoder #(.LAMP_N(LAMP_N)) u_lamp_decoder (
        .counter (counter),
        .lamp    (lamp)
    );

endmodule

// File: tb/tb_bound_flasher_ctrl.sv
// Scoreboard bench for bound_flasher_ctrl; the counter input is driven
// from a waypoint-list model of the lamp pattern.
module tb_bound_flasher_ctrl;

`ifdef FLASHER_KICKBACK_EN
    localparam bit KICK = 1'b1;
`else
    localparam bit KICK = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  cmd;
        logic        ld_en;
        logic [4:0]  ld;
        logic [15:0] lamp;
        logic        busy;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        flick;
    logic [4:0]  counter;
    logic [1:0]  count_state;
    logic [4:0]  counter_load;
    logic        counter_load_en;
    logic [15:0] lamp;
    logic        busy;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   busy_run = 0;
    int   last_run = 0;

    // Model: m_phase is the index into the waypoint list, -1 when idle
    int targets[6] = '{16, 5, 10, 0, 5, 0};
    int m_phase = -1;
    int m_cnt = 0;

    bound_flasher_ctrl #(.LAMP_N(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flick           (flick),
        .counter         (counter),
        .count_state     (count_state),
        .counter_load    (counter_load),
        .counter_load_en (counter_load_en),
        .lamp            (lamp),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic applyStimulus(input logic f, input logic r, input logic ill);
        exp_t e;
        int   cin;
        int   nxt;
        @(posedge clk);
        #1;
        cin     = ill ? 20 : m_cnt;
        flick   = f;
        rst_n   = r;
        counter = 5'(cin);
        e.lamp  = '0;
        for (int i = 0; i < 16; i++) e.lamp[i] = (cin > i);
        e.ld    = 5'd0;
        e.ld_en = 1'b0;
        e.busy  = r && (m_phase >= 0);
        if (!r) begin
            e.cmd   = 2'b00;
            m_phase = -1;
            m_cnt   = 0;
        end else if (cin > 16) begin
            e.ld_en = 1'b1;
            e.cmd   = 2'b00;
            m_phase = -1;
            m_cnt   = 0;
        end else begin
            nxt = m_phase;
            if (m_phase < 0) begin
                if (f) nxt = 0;
            end else if (cin == targets[m_phase]) begin
                if (KICK && f && m_phase == 1)      nxt = 0;
                else if (KICK && f && m_phase == 3) nxt = 2;
                else if (m_phase == 5)              nxt = -1;
                else                                nxt = m_phase + 1;
            end
            m_phase = nxt;
            if (nxt < 0) begin
                e.cmd = 2'b00;
            end else if (targets[nxt] > cin) begin
                e.cmd = 2'b01;
                m_cnt = cin + 1;
            end else begin
                e.cmd = 2'b10;
                m_cnt = cin - 1;
            end
        end
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (busy === 1'b1) begin
            busy_run++;
        end else if (busy_run != 0) begin
            last_run = busy_run;
            busy_run = 0;
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("count_state", 32'(count_state), 32'(e.cmd));
            checkOutput("counter_load_en", 32'(counter_load_en), 32'(e.ld_en));
            checkOutput("counter_load", 32'(counter_load), 32'(e.ld));
            checkOutput("lamp", 32'(lamp), 32'(e.lamp));
            checkOutput("busy", 32'(busy), 32'(e.busy));
        end
    end

    initial begin
        rst_n   = 1'b0;
        flick   = 1'b0;
        counter = 5'd0;

        // Reset then idle
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (6) applyStimulus(1'b0, 1'b1, 1'b0);

        // Full pass without kickback
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (60) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("pass_len", 32'(last_run), 32'd52);

        // Flick at DN5's target
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 100 && !(m_phase == 1 && m_cnt == 5); i++)
            applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 200 && m_phase >= 0; i++)
            applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b0);

        // Flick at DN0A's 0, then at DN0B's 0
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 100 && !(m_phase == 3 && m_cnt == 0); i++)
            applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 200 && !(m_phase == 5 && m_cnt == 0); i++)
            applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b0);

        // Illegal counter in UP10
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 100 && !(m_phase == 2 && m_cnt == 7); i++)
            applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b0);

        // Reset mid-way through UP16
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 40 && !(m_phase == 0 && m_cnt == 12); i++)
            applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b0);

        // Random flick traffic, including occasional illegal counters
        for (int p = 0; p < 4; p++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            for (int i = 0; i < 150; i++)
                applyStimulus(1'($urandom_range(0, 3) == 0), 1'b1, 1'($urandom_range(0, 99) == 0));
            applyStimulus(1'b0, 1'b0, 1'b0);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bound_flasher_ctrl.md
# bound_flasher_ctrl

Sequencing FSM for the bound flasher. It sits directly upstream of `next_counter_generator` and drives that block's `count_state`, `counter_load` and `counter_load_en` inputs. It consumes the registered lamp counter and the `flick` input, and walks the lamp pattern 0→16→5→10→0→5→0 with flick kickback. It also decodes the counter into the 16-bit lamp vector.

## Interface
Parameters:
- `LAMP_N`, 16: number of lamps and the peak counter value; the counter is 5 bits.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `flick`  input  1  start/kickback request, level-sampled on `clk`.
- `counter`  input  5  registered counter, fed back from the counter register that stores `counter_n`.
- `count_state`  output  2  command to `next_counter_generator`: `COUNT_DIS`, `COUNT_UP_EN`, `COUNT_DOWN_EN` or `COUNT_HOLD`.
- `counter_load`  output  5  load value.
- `counter_load_en`  output  1  load strobe; overrides `count_state` downstream.
- `lamp`  output  16  lamp vector; `lamp[i] = (counter > i)`.
- `busy`  output  1  high whenever the state is not IDLE.

## Operation
States and targets, in sequence:
- IDLE: outputs `COUNT_DIS`.
- UP16: counts up, target 16.
- DN5: counts down, target 5.
- UP10: counts up, target 10.
- DN0A: counts down, target 0.
- UP5: counts up, target 5.
- DN0B: counts down, target 0.

Transitions:
- IDLE→UP16 when `flick`=1.
- Every other state advances to the next state in the sequence when `counter` equals its target. DN0B advances to IDLE.
- Kickback, DN5: at `counter`==5 with `flick`=1 → UP16 instead of UP10.
- Kickback, DN0A: at `counter`==0 with `flick`=1 → UP10 instead of UP5.
- DN0B has no kickback. `flick` is ignored everywhere except IDLE and the two kickback points.

Output rules:
- `count_state` is a function of the next state (Mealy). The command for the new state is issued in the same cycle as the target hit, so the counter turns around with no dwell cycle (…15,16,15…).
- Illegal counter: if `counter` > 16 in any state, assert `counter_load_en`=1 with `counter_load`=0 for one cycle and go to IDLE.
- Otherwise `counter_load_en`=0 and `counter_load`=0.
- `COUNT_HOLD` is never issued by this FSM. It is reserved.

Reset:
- `rst_n`=0 at any edge forces state to IDLE, including mid-sequence. During reset, outputs are: `count_state`=`COUNT_DIS`, `counter_load_en`=0, `counter_load`=0, `busy`=0.
- `lamp` follows `counter`, which the downstream register also resets to 0.

## Timing
- State register updates on `clk`. Outputs are combinational from state, `counter` and `flick`. Latency from `flick` sample to the first counter increment is 0 cycles: the counter is 1 after the accepting edge.
- A full pass with no kickback takes 52 edges from flick acceptance until IDLE is re-entered with `counter`=0: 16 + 11 + 5 + 10 + 5 + 5.
- A flick held high across the final DN0B→IDLE edge is not seen as a new start on that edge. A new pass starts only from an IDLE-state sample.
- Simultaneous events: an illegal counter takes priority over a target hit or kickback. Reset takes priority over everything.

## Configuration
- `FLASHER_KICKBACK_EN` defined: kickback at DN5 and DN0A works as described above.
- Not defined: DN5 always goes to UP10 and DN0A always goes to UP5, and `flick` is observed only in IDLE.

## Structure
- Shared package `flasher_pkg` holds:
  - `COUNT_DIS`=2'b00, `COUNT_UP_EN`=2'b01, `COUNT_DOWN_EN`=2'b10, `COUNT_HOLD`=2'b11
  - `COUNTER_INIT`=5'd0
  - `LAMP_MAX`=5'd16
  - a state enum `flash_state_t`
- The package replaces the ad-hoc constant include for both this block and `next_counter_generator`.
- One sub-module, `lamp_decoder`: combinational 5-bit counter to 16-bit thermometer. Values ≥16 give all ones.

## Test plan
- Reset then idle: `rst_n`=0 for 2 cycles, `flick`=0 → `count_state`=00, `lamp`=0, `busy`=0 indefinitely.
- Full pass: 1-cycle `flick` in IDLE → the counter trace 0→16→5→10→0→5→0 is reached in exactly 52 edges, `lamp`=16'hFFFF at the peak, and the FSM returns to IDLE.
- Kickback at 5: hold `flick`=1 when DN5 hits 5 → the counter goes 5→6…16 again. Without the macro, it goes 5→10 instead.
- Kickback at 0: `flick`=1 when DN0A reaches 0 → the counter goes 0→10, not 0→5. A flick at DN0B's 0 → IDLE.
- Illegal counter: force `counter`=5'd20 in UP10 → a one-cycle `counter_load_en`=1 with `counter_load`=0, then IDLE.
- Mid-sequence reset: `rst_n`=0 at `counter`=12 in UP16 → next edge IDLE, `count_state`=`COUNT_DIS`, and the counter is 0.
